// File: rtl/flush_cache_pkg.sv
// Shared types and helpers for the tile cache write-back engine.
// Lane-select and bus constants live here so fill and flush agree.
package flush_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [3:0] WB_SEL_NONE = 4'h0;
  localparam logic [3:0] WB_SEL_ALL  = 4'hf;

  function automatic logic [3:0] lane_sel(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

endpackage

// File: rtl/flush_addr_gen.sv
// Tile walk counters and external byte-address generation for
// the flush engine; latches tile geometry on start.
module flush_addr_gen #(
  parameter int IM_WIDTH = 640,
  parameter int AW       = 5,
  parameter int AH       = 5
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_adv,
  input  logic [9:0]    i_pixel_c,
  input  logic [9:0]    i_pixel_l,
  input  logic [AW:0]   i_cache_w,
  input  logic [AH:0]   i_cache_h,
  input  logic [31:0]   i_im_addr,
  output logic [AW-1:0] o_col,
  output logic [AH-1:0] o_line,
  output logic [31:0]   o_byte_addr,
  output logic          o_last_in_line,
  output logic          o_last_pixel,
  output logic          o_same_word
);

  localparam logic [AW:0] W_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AH:0] H_MAX = {1'b1, {AH{1'b0}}};

  logic [9:0]    r_pc;
  logic [9:0]    r_pl;
  logic [AW:0]   r_w;
  logic [AH:0]   r_h;
  logic [31:0]   r_base;
  logic [AW-1:0] r_col;
  logic [AH-1:0] r_line;
  logic [31:0]   w_row;
  logic          w_last_col;
  logic          w_last_line;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc   <= '0;
      r_pl   <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_base <= '0;
      r_col  <= '0;
      r_line <= '0;
    end else if (i_start) begin
      r_pc   <= i_pixel_c;
      r_pl   <= i_pixel_l;
      r_w    <= (i_cache_w > W_MAX) ? W_MAX : i_cache_w;
      r_h    <= (i_cache_h > H_MAX) ? H_MAX : i_cache_h;
      r_base <= i_im_addr;
      r_col  <= '0;
      r_line <= '0;
    end else if (i_adv) begin
      if (w_last_col) begin
        r_col  <= '0;
        r_line <= r_line + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_row       = 32'(r_pl) + 32'(r_line);
  assign o_byte_addr = r_base + w_row * 32'(IM_WIDTH)
                     + 32'(r_pc) + 32'(r_col);

  assign w_last_col  = ({1'b0, r_col} == r_w - (AW+1)'(1));
  assign w_last_line = ({1'b0, r_line} == r_h - (AH+1)'(1));

  assign o_col          = r_col;
  assign o_line         = r_line;
  assign o_last_in_line = w_last_col;
  assign o_last_pixel   = w_last_col && w_last_line;
  // Next pixel is byte_addr+1 only while staying on this tile line.
  assign o_same_word    = !w_last_col && (o_byte_addr[1:0] != 2'b11);

endmodule

// File: rtl/flush_cache.sv
// Tile cache write-back engine: Wishbone byte-lane writer.
// FLUSH_CACHE_PACK_EN packs neighbouring pixels into one word write.
module flush_cache
  import flush_cache_pkg::*;
#(
  parameter int IM_WIDTH    = 640,
  parameter int IM_HEIGHT   = 480,
  parameter int ADDR_SIZE_W = 5,
  parameter int ADDR_SIZE_H = 5,
  parameter int DATA_SIZE   = 8
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic [9:0]                     pixel_c_I,
  input  logic [9:0]                     pixel_l_I,
  input  logic [ADDR_SIZE_W:0]           cache_w_I,
  input  logic [ADDR_SIZE_H:0]           cache_h_I,
  input  logic [31:0]                    im_addr_I,
  input  logic                           go,
  output logic                           flush_done,
  output logic                           busy,
  output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] addr,
  input  logic [DATA_SIZE-1:0]           pixel_in,
  output logic [31:0]                    p_wb_DAT_O,
  input  logic                           p_wb_ACK_I,
  output logic                           p_wb_STB_O,
  output logic                           p_wb_CYC_O,
  output logic                           p_wb_WE_O,
  output logic                           p_wb_LOCK_O,
  output logic [3:0]                     p_wb_SEL_O,
  output logic [31:0]                    p_wb_ADR_O
);

`ifdef FLUSH_CACHE_PACK_EN
  localparam bit PACK_EN = 1'b1;
`else
  localparam bit PACK_EN = 1'b0;
`endif

  state_t r_state;
  state_t w_next;

  logic                   r_stb;
  logic [3:0]             r_sel;
  logic [31:0]            r_dat;
  logic [31:0]            r_adr;
  logic [ADDR_SIZE_W-1:0] w_col;
  logic [ADDR_SIZE_H-1:0] w_line;
  logic [31:0]            w_byte;
  logic                   w_last_in_line;
  logic                   w_last_pixel;
  logic                   w_same_word;
  logic                   w_start;
  logic                   w_zero;
  logic                   w_ack;
  logic                   w_pack_adv;

  assign w_start    = (r_state == S_IDLE) && go;
  assign w_zero     = (cache_w_I == '0) || (cache_h_I == '0);
  assign w_ack      = (r_state == S_WRITE) && p_wb_ACK_I;
  assign w_pack_adv = PACK_EN && (r_state == S_LOAD) && w_same_word;

  flush_addr_gen #(
    .IM_WIDTH (IM_WIDTH),
    .AW       (ADDR_SIZE_W),
    .AH       (ADDR_SIZE_H)
  ) u_agen (
    .clk            (clk),
    .i_rst          (RST),
    .i_start        (w_start),
    .i_adv          (w_ack || w_pack_adv),
    .i_pixel_c      (pixel_c_I),
    .i_pixel_l      (pixel_l_I),
    .i_cache_w      (cache_w_I),
    .i_cache_h      (cache_h_I),
    .i_im_addr      (im_addr_I),
    .o_col          (w_col),
    .o_line         (w_line),
    .o_byte_addr    (w_byte),
    .o_last_in_line (w_last_in_line),
    .o_last_pixel   (w_last_pixel),
    .o_same_word    (w_same_word)
  );

  always_ff @(posedge clk) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (go) w_next = w_zero ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = w_pack_adv ? S_FETCH : S_WRITE;
      S_WRITE: begin
        if (p_wb_ACK_I) w_next = w_last_pixel ? S_DONE : S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_stb <= 1'b0;
      r_sel <= WB_SEL_NONE;
      r_dat <= '0;
      r_adr <= '0;
    end else begin
      if (w_start) begin
        r_sel <= WB_SEL_NONE;
        r_dat <= '0;
      end
      if (r_state == S_LOAD) begin
        r_sel <= r_sel | lane_sel(w_byte[1:0]);
        r_dat[{w_byte[1:0], 3'b000} +: 8] <= pixel_in;
        if (w_next == S_WRITE) begin
          r_stb <= 1'b1;
          r_adr <= {w_byte[31:2], 2'b00};
        end
      end
      if (w_ack) begin
        r_stb <= 1'b0;
        r_sel <= WB_SEL_NONE;
        r_dat <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && w_start && !w_zero)
      assert (32'(pixel_l_I) + 32'(cache_h_I) <= 32'(IM_HEIGHT));
  end

  assign flush_done  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign addr        = {w_line, w_col};
  assign p_wb_STB_O  = r_stb;
  assign p_wb_CYC_O  = r_stb;
  assign p_wb_WE_O   = r_stb;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = r_sel;
  assign p_wb_DAT_O  = r_dat;
  assign p_wb_ADR_O  = r_adr;

endmodule

// File: tb/tb_flush_cache.sv
// Scoreboard bench for flush_cache; expectations follow
// FLUSH_CACHE_PACK_EN when the bench is built with it.
module tb_flush_cache;

  logic        clk = 1'b0;
  logic        RST;
  logic [9:0]  pixel_c_I;
  logic [9:0]  pixel_l_I;
  logic [5:0]  cache_w_I;
  logic [5:0]  cache_h_I;
  logic [31:0] im_addr_I;
  logic        go;
  logic        flush_done;
  logic        busy;
  logic [9:0]  addr;
  logic [7:0]  pixel_in;
  logic [31:0] dat_o;
  logic        ack;
  logic        stb, cyc, we, lock;
  logic [3:0]  sel;
  logic [31:0] adr;

  always #5 clk = ~clk;

  flush_cache dut (
    .clk        (clk),
    .RST        (RST),
    .pixel_c_I  (pixel_c_I),
    .pixel_l_I  (pixel_l_I),
    .cache_w_I  (cache_w_I),
    .cache_h_I  (cache_h_I),
    .im_addr_I  (im_addr_I),
    .go         (go),
    .flush_done (flush_done),
    .busy       (busy),
    .addr       (addr),
    .pixel_in   (pixel_in),
    .p_wb_DAT_O (dat_o),
    .p_wb_ACK_I (ack),
    .p_wb_STB_O (stb),
    .p_wb_CYC_O (cyc),
    .p_wb_WE_O  (we),
    .p_wb_LOCK_O(lock),
    .p_wb_SEL_O (sel),
    .p_wb_ADR_O (adr)
  );

  // Cache RAM model: pixel = low address byte + 0x10, one cycle latency.
  always @(posedge clk) pixel_in <= addr[7:0] + 8'h10;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  ack_cnt = 0;
  int  done_cnt = 0;
  int  wait_n = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    wr_t e;
    e.adr = a;
    e.sel = s;
    e.dat = d;
    q.push_back(e);
  endtask

  // Slave + monitor: acks after wait_n extra cycles, checks hold-stability.
  logic        active = 1'b0;
  int          wcnt = 0;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;

  initial ack = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    ack = 1'b0;
    if (stb) begin
      if (!active) begin
        active = 1'b1;
        wcnt = 0;
        s_adr = adr;
        s_dat = dat_o;
        s_sel = sel;
      end else begin
        check("hold_adr", adr, s_adr);
        check("hold_dat", dat_o, s_dat);
        check("hold_sel", {28'd0, sel}, {28'd0, s_sel});
        check("hold_cyc_we", {30'd0, cyc, we}, 32'd3);
      end
      if (wcnt == wait_n) begin
        ack = 1'b1;
        active = 1'b0;
        ack_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none", adr);
        end else begin
          e = q.pop_front();
          check("wr_adr", adr, e.adr);
          check("wr_sel", {28'd0, sel}, {28'd0, e.sel});
          check("wr_dat", dat_o, e.dat);
          check("wr_ctl", {29'd0, cyc, we, lock}, 32'd6);
        end
      end else begin
        wcnt++;
      end
    end else begin
      active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (flush_done) begin
      done_cnt++;
      check("busy_at_done", {31'd0, busy}, 32'd1);
    end
  end

  task automatic set_tile(input int c, input int l, input int w,
                          input int h, input logic [31:0] b);
    pixel_c_I = 10'(c);
    pixel_l_I = 10'(l);
    cache_w_I = 6'(w);
    cache_h_I = 6'(h);
    im_addr_I = b;
  endtask

  task automatic run_tile(input string name, input bit glitch);
    bit got = 1'b0;
    int d0 = done_cnt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (flush_done) begin
        go = 1'b0;
        got = 1'b1;
        break;
      end
      go = glitch && (i % 4 == 1);
    end
    go = 1'b0;
    check({name, "_done"}, {31'd0, got}, 32'd1);
    repeat (12) @(negedge clk);
    check({name, "_one_done"}, done_cnt - d0, 32'd1);
    check({name, "_q_empty"}, q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int a0;
    bit got;
    int d0;
    RST = 1'b1;
    go = 1'b0;
    set_tile(0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_lock", {31'd0, lock}, 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_addr", {22'd0, addr}, 32'd0);
    check("rst_flags", {30'd0, flush_done, busy}, 32'd0);

    // 4x2 tile at origin, zero-wait slave.
    wait_n = 0;
`ifdef FLUSH_CACHE_PACK_EN
    push(32'h1000, 4'hf, 32'h13121110);
    push(32'h1280, 4'hf, 32'h33323130);
`else
    push(32'h1000, 4'h1, 32'h00000010);
    push(32'h1000, 4'h2, 32'h00001100);
    push(32'h1000, 4'h4, 32'h00120000);
    push(32'h1000, 4'h8, 32'h13000000);
    push(32'h1280, 4'h1, 32'h00000030);
    push(32'h1280, 4'h2, 32'h00003100);
    push(32'h1280, 4'h4, 32'h00320000);
    push(32'h1280, 4'h8, 32'h33000000);
`endif
    set_tile(0, 0, 4, 2, 32'h1000);
    run_tile("t4x2", 1'b0);

    // Tile straddling a word boundary.
    push(32'h2000, 4'h8, 32'h10000000);
    push(32'h2004, 4'h1, 32'h00000011);
    set_tile(3, 0, 2, 1, 32'h2000);
    run_tile("straddle", 1'b0);

    // Five wait states with go pulses while busy.
    wait_n = 5;
`ifdef FLUSH_CACHE_PACK_EN
    push(32'h280, 4'h6, 32'h00111000);
`else
    push(32'h280, 4'h2, 32'h00001000);
    push(32'h280, 4'h4, 32'h00110000);
`endif
    set_tile(1, 1, 2, 1, 32'h0);
    a0 = ack_cnt;
    run_tile("wait5", 1'b1);
`ifdef FLUSH_CACHE_PACK_EN
    check("wait5_acks", ack_cnt - a0, 32'd1);
`else
    check("wait5_acks", ack_cnt - a0, 32'd2);
`endif
    wait_n = 0;

    // Zero width: straight to done, no bus cycle.
    set_tile(0, 0, 0, 2, 32'h3000);
    a0 = ack_cnt;
    d0 = done_cnt;
    got = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      go = 1'b0;
      check("zero_cyc", {31'd0, cyc}, 32'd0);
      if (flush_done) got = 1'b1;
    end
    check("zero_done", {31'd0, got}, 32'd1);
    repeat (4) @(negedge clk);
    check("zero_no_write", ack_cnt - a0, 32'd0);
    check("zero_one_done", done_cnt - d0, 32'd1);

    // Reset during the third write, then restart.
    wait_n = 3;
    push(32'h000, 4'h1, 32'h00000010);
    push(32'h280, 4'h1, 32'h00000030);
    set_tile(0, 0, 1, 4, 32'h0);
    a0 = ack_cnt;
    d0 = done_cnt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ack_cnt - a0 == 2 && stb && !ack) begin
        got = 1'b1;
        break;
      end
    end
    check("rst3_reached", {31'd0, got}, 32'd1);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("rst3_stb", {31'd0, stb}, 32'd0);
    check("rst3_cyc", {31'd0, cyc}, 32'd0);
    repeat (10) @(negedge clk);
    check("rst3_no_done", done_cnt - d0, 32'd0);
    check("rst3_acks", ack_cnt - a0, 32'd2);
    check("rst3_q_empty", q.size(), 32'd0);

    wait_n = 0;
    push(32'h100, 4'h1, 32'h00000010);
    set_tile(0, 0, 1, 1, 32'h100);
    run_tile("restart", 1'b0);

    check("final_q_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
